key_event_arbiter: RTL and testbench
====================================

Name: key_event_arbiter

Overview:
- Collects the one-cycle "key pressed" pulses produced by N independent debounce blocks.
- Latches each pulse as a pending request and arbitrates fairly (round-robin) among the pending keys.
- Queues the winning key IDs in a small FIFO and presents them to a single consumer (menu/control FSM) over a valid/ready handshake.
- Sits between the debounce bank and the top-level control logic, so no press is lost when several keys fire close together or the consumer stalls.

Parameters:
- N_KEYS, 4, number of debounced key inputs (2..16).
- ID_W, 2, width of key ID; must satisfy 2**ID_W >= N_KEYS.
- FIFO_DEPTH, 4, event FIFO entries (power of 2, 2..16).
- CNT_W, 8, width of the saturating drop counter.

Ports:
- sys_clk, in, 1, system clock; all logic on rising edge.
- sys_rst_n, in, 1, asynchronous active-low reset.
- key_pulse, in, N_KEYS, one-cycle-high press pulses, bit i = key i.
- evt_valid, out, 1, FIFO head holds an event.
- evt_id, out, ID_W, key ID at FIFO head; valid only while evt_valid=1.
- evt_ready, in, 1, consumer accepts head when evt_valid&&evt_ready.
- pending, out, N_KEYS, per-key latched request not yet queued.
- drop_o, out, 1, one-cycle pulse when a press was discarded.
- drop_cnt, out, CNT_W, saturating count of discarded presses.

Behaviour:
- Reset (async assert, sync use on release): pending=0, FIFO empty (evt_valid=0, evt_id=0), rr_ptr=0, drop_o=0, drop_cnt=0. Reset mid-operation discards all pending and queued events.
- Pending latch: pending[i] is set at the edge after key_pulse[i]=1.
  - Pulse and grant of the same key in one cycle: pending[i] stays 1, and the new press is retained.
  - Pulse while pending[i]=1 and key i not granted that cycle: the press is dropped. drop_o=1 next cycle. drop_cnt+1, saturating at all-ones.
  - Multiple keys dropped in one cycle: single drop_o pulse; drop_cnt increments by 1 only.
- Arbitration: evaluated each cycle only when the registered FIFO count < FIFO_DEPTH.
  - A pop in the same cycle does not free space for a push; a full FIFO blocks the grant for that cycle.
  - Grant goes to the first i with pending[i]=1, searching rr_ptr, rr_ptr+1, ... modulo N_KEYS. At most one grant per cycle.
  - On grant g: push g into the FIFO, clear pending[g] (unless re-pulsed per the rule above), rr_ptr <= (g+1) mod N_KEYS. Wrap is correct for non-power-of-2 N_KEYS.
  - No grant: rr_ptr holds.
- FIFO:
  - Registered count and read/write pointers; evt_valid = (count != 0); evt_id = entry at read pointer.
  - Pop on evt_valid&&evt_ready. Push and pop in the same cycle leaves count unchanged. evt_ready with evt_valid=0 is ignored.
  - evt_id and evt_valid stay stable while evt_valid=1 and evt_ready=0.
- Latency: key_pulse at cycle t -> pending visible t+1 -> pushed at end of t+1 -> evt_valid=1 at t+2. Applies when the FIFO is not full and the key wins arbitration.
- Order: FIFO output order equals grant order. Simultaneous pulses are queued in round-robin order starting from rr_ptr.
- No combinational path from key_pulse to any output. evt_valid/evt_id depend only on registers.

Test Plan:
- Single press: reset, then key_pulse=4'b0100 for 1 cycle, evt_ready=1 -> evt_valid=1 two cycles later with evt_id=2, held 1 cycle. pending returns to 0. drop_cnt=0.
- Simultaneous presses: key_pulse=4'b1011 in one cycle, rr_ptr=0, evt_ready=0 -> FIFO fills in order IDs 0,1,3 over three cycles. Then evt_ready=1 pops 0,1,3. Final rr_ptr=0.
- Fairness/wrap: key 3 and key 0 pulsed every 4 cycles, evt_ready=1 -> grants alternate 3,0,3,0. Neither key starves. No drops.
- Back-pressure/full: evt_ready=0, press keys 0,1,2,3, then key 0 again -> FIFO holds 4 entries, count=4. Second key-0 press stays in pending[0]. After one pop, ID 0 is pushed, with no push in the pop cycle itself.
- Drop/saturation: with pending[1]=1 and FIFO full, pulse key 1 300 times with CNT_W=8 -> drop_o pulses each time. drop_cnt saturates at 255.
- Async reset mid-stream: assert sys_rst_n=0 between clock edges with 3 queued events -> evt_valid, pending, drop_cnt go to 0 immediately. After release, the first press yields ID via the normal 2-cycle latency with rr_ptr=0.

Source files
------------

// File: rtl/key_event_arbiter_if.sv
// Event channel from the key arbiter to its single consumer.
// A transfer happens on a rising clock edge where evt_valid && evt_ready; evt_valid/evt_id hold until then.
interface key_event_arbiter_if #(
    parameter int ID_W = 2
) ();
    logic            evt_valid;
    logic [ID_W-1:0] evt_id;
    logic            evt_ready;

    modport master (output evt_valid, output evt_id, input evt_ready);
    modport slave  (input evt_valid, input evt_id, output evt_ready);
endinterface

// File: rtl/key_event_arbiter.sv
// Latches debounced key press pulses, arbitrates round-robin among pending keys and
// queues winning key IDs in a small FIFO read over a valid/ready channel.
module key_event_arbiter #(
    parameter int N_KEYS     = 4,
    parameter int ID_W       = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic [N_KEYS-1:0]         key_pulse,
    key_event_arbiter_if.master       evt,
    output logic [N_KEYS-1:0]         pending,
    output logic                      drop_o,
    output logic [CNT_W-1:0]          drop_cnt
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [ID_W:0]   NK_C    = (ID_W+1)'(N_KEYS);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_KEYS - 1);

    logic [N_KEYS-1:0] pending_q, pending_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic              drop_q, drop_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic [ID_W-1:0]   mem_q [FIFO_DEPTH];
    logic [ID_W-1:0]   mem_d [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    logic              can_push;
    logic              grant_vld;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W:0]     scan;
    logic [N_KEYS-1:0] grant_vec;
    logic [N_KEYS-1:0] drop_vec;
    logic              push, pop;

    // Space is judged on the registered count only, so a same-cycle pop never frees a slot.
    assign can_push = (count_q != DEPTH_C);

    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        scan      = '0;
        for (int k = 0; k < N_KEYS; k++) begin
            scan = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (scan >= NK_C) begin
                scan = scan - NK_C;
            end
            if (can_push && !grant_vld && pending_q[scan[ID_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_id  = scan[ID_W-1:0];
            end
        end
    end

    always_comb begin
        grant_vec = '0;
        if (grant_vld) begin
            grant_vec = {{(N_KEYS-1){1'b0}}, 1'b1} << grant_id;
        end
        // A re-pulse of the granted key is kept as a fresh request, never dropped.
        drop_vec   = key_pulse & pending_q & ~grant_vec;
        pending_d  = (pending_q & ~grant_vec) | key_pulse;
        drop_d     = |drop_vec;
        drop_cnt_d = drop_cnt_q;
        if (drop_d && (drop_cnt_q != {CNT_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
        rr_ptr_d = rr_ptr_q;
        if (grant_vld) begin
            rr_ptr_d = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
        end
    end

    assign push = grant_vld;
    assign pop  = (count_q != '0) && evt.evt_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = grant_id;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pending_q  <= '0;
            rr_ptr_q   <= '0;
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            pending_q  <= pending_d;
            rr_ptr_q   <= rr_ptr_d;
            drop_q     <= drop_d;
            drop_cnt_q <= drop_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign evt.evt_valid = (count_q != '0);
    assign evt.evt_id    = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign pending       = pending_q;
    assign drop_o        = drop_q;
    assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_key_event_arbiter.sv
// Directed bench for key_event_arbiter: stimulus pushes expected IDs into a queue,
// a negedge monitor pops and compares on every accepted event.
module tb_key_event_arbiter;
  logic       sys_clk;
  logic       sys_rst_n;
  logic [3:0] key_pulse;
  logic [3:0] pending;
  logic       drop_o;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  key_event_arbiter_if #(.ID_W(2)) evt_if ();

  key_event_arbiter #(
    .N_KEYS(4), .ID_W(2), .FIFO_DEPTH(4), .CNT_W(8)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key_pulse(key_pulse),
    .evt      (evt_if),
    .pending  (pending),
    .drop_o   (drop_o),
    .drop_cnt (drop_cnt)
  );

  // clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string nm, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] keys);
    key_pulse = keys;
    step();
    key_pulse = 4'b0000;
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    key_pulse = 4'b0000;
    evt_if.evt_ready = 1'b0;
    exp_q.delete();
    step();
    step();
    #2 sys_rst_n = 1'b1;
    step();
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((evt_if.evt_valid || pending != 4'b0000 || exp_q.size() != 0) && n < 40) begin
      step();
      n++;
    end
    check({nm, "_idle_timeout"}, (n < 40) ? 1 : 0, 1);
  endtask

  // scoreboard monitor
  initial begin
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n && evt_if.evt_valid && evt_if.evt_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", evt_if.evt_id, 4'hF);
        end else begin
          check("evt_id_order", evt_if.evt_id, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    do_reset();
    check("rst_evt_valid", evt_if.evt_valid, 0);
    check("rst_evt_id", evt_if.evt_id, 0);
    check("rst_pending", pending, 0);
    check("rst_drop_o", drop_o, 0);
    check("rst_drop_cnt", drop_cnt, 0);

    // single press, two-cycle latency, held one cycle
    evt_if.evt_ready = 1'b1;
    exp_q.push_back(2'd2);
    pulse(4'b0100);
    check("single_pending", pending, 4'b0100);
    check("single_valid_t1", evt_if.evt_valid, 0);
    step();
    check("single_valid_t2", evt_if.evt_valid, 1);
    check("single_id_t2", evt_if.evt_id, 2);
    check("single_pending_clr", pending, 0);
    step();
    check("single_valid_t3", evt_if.evt_valid, 0);
    check("single_drop_cnt", drop_cnt, 0);

    // simultaneous presses from rr_ptr=0 with a stalled consumer
    do_reset();
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd3);
    pulse(4'b1011);
    check("sim_pending_1", pending, 4'b1011);
    step();
    check("sim_pending_2", pending, 4'b1010);
    check("sim_head_0", evt_if.evt_id, 0);
    step();
    check("sim_pending_3", pending, 4'b1000);
    step();
    check("sim_pending_4", pending, 4'b0000);
    check("sim_head_stable", evt_if.evt_id, 0);
    evt_if.evt_ready = 1'b1;
    wait_idle("sim");
    // rr_ptr back at 0: key 0 must beat key 3
    exp_q.push_back(2'd0); exp_q.push_back(2'd3);
    pulse(4'b1001);
    wait_idle("rr_zero");

    // fairness: move rr_ptr to 1, then keys 3 and 0 together alternate 3,0
    exp_q.push_back(2'd0);
    pulse(4'b0001);
    wait_idle("rr_one");
    for (int p = 0; p < 4; p++) begin
      exp_q.push_back(2'd3); exp_q.push_back(2'd0);
      pulse(4'b1001);
      step(); step(); step();
    end
    wait_idle("fair");
    check("fair_drop_cnt", drop_cnt, 0);

    // back-pressure: rr_ptr=1, fill FIFO, extra key-0 press waits in pending
    evt_if.evt_ready = 1'b0;
    exp_q.push_back(2'd1); exp_q.push_back(2'd2); exp_q.push_back(2'd3);
    exp_q.push_back(2'd0); exp_q.push_back(2'd0);
    pulse(4'b1111);
    step(); step(); step(); step();
    check("full_pending_empty", pending, 0);
    pulse(4'b0001);
    check("full_pending_held", pending, 4'b0001);
    step();
    check("full_pending_held2", pending, 4'b0001);
    check("full_head", evt_if.evt_id, 1);
    evt_if.evt_ready = 1'b1;
    step();
    evt_if.evt_ready = 1'b0;
    check("pop_cycle_no_push", pending, 4'b0001);
    step();
    check("push_after_pop", pending, 4'b0000);
    check("full_head_after", evt_if.evt_id, 2);

    // drops: FIFO full, keys 0 and 1 pending
    pulse(4'b0011);
    check("drop_setup_pending", pending, 4'b0011);
    check("drop_setup_drop_o", drop_o, 0);
    pulse(4'b0011);
    check("multi_drop_o", drop_o, 1);
    check("multi_drop_cnt", drop_cnt, 1);
    for (int i = 0; i < 299; i++) begin
      pulse(4'b0010);
      check("drop_o_pulse", drop_o, 1);
      if (i == 98) check("drop_cnt_mid", drop_cnt, 100);
    end
    check("drop_cnt_sat", drop_cnt, 255);
    step();
    check("drop_o_idle", drop_o, 0);
    check("drop_cnt_hold", drop_cnt, 255);
    check("drop_pending_kept", pending, 4'b0011);

    // asynchronous reset between edges with a full FIFO
    #2 sys_rst_n = 1'b0;
    #1;
    check("arst_evt_valid", evt_if.evt_valid, 0);
    check("arst_pending", pending, 0);
    check("arst_drop_cnt", drop_cnt, 0);
    exp_q.delete();
    step();
    #2 sys_rst_n = 1'b1;
    step();
    evt_if.evt_ready = 1'b1;
    exp_q.push_back(2'd1); exp_q.push_back(2'd3);
    pulse(4'b1010);
    check("post_rst_valid_t1", evt_if.evt_valid, 0);
    step();
    check("post_rst_valid_t2", evt_if.evt_valid, 1);
    check("post_rst_id", evt_if.evt_id, 1);
    wait_idle("post_rst");
    check("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
